// File: rtl/pipelined_addsub.sv
// WIDTH-bit pipelined add/subtract: STAGES carry-ripple chunks of WIDTH/STAGES bits, registered between chunks.
// Optional SATURATE_EN: on signed overflow the result clamps to the signed limit (ovf/cout stay raw).

module pipelined_addsub_stage #(
    parameter int WIDTH = 16,
    parameter int CW    = 4,
    parameter int IDX   = 0,
    parameter bit LAST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             v_i,
    input  logic             c_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    output logic             v_o,
    output logic             c_o,
    output logic             ovf_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] s_o
);
    logic [CW:0]      chunk;
    logic [WIDTH-1:0] s_d;
    logic             ovf_d;
    logic             v_q, c_q, ovf_q;
    logic [WIDTH-1:0] a_q, b_q, s_q;

    always_comb begin
        chunk = {1'b0, a_i[IDX*CW +: CW]} + {1'b0, b_i[IDX*CW +: CW]} + {{CW{1'b0}}, c_i};
        s_d   = s_i;
        s_d[IDX*CW +: CW] = chunk[CW-1:0];
        ovf_d = 1'b0;
        if (LAST) begin
            // carry into the MSB is recovered from the MSB sum bit and its operand bits
            ovf_d = a_i[WIDTH-1] ^ b_i[WIDTH-1] ^ chunk[CW-1] ^ chunk[CW];
`ifdef SATURATE_EN
            if (ovf_d)
                s_d = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            ovf_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
        end else if (en_i) begin
            v_q   <= v_i;
            c_q   <= chunk[CW];
            ovf_q <= ovf_d;
            a_q   <= a_i;
            b_q   <= b_i;
            s_q   <= s_d;
        end
    end

    assign v_o   = v_q;
    assign c_o   = c_q;
    assign ovf_o = ovf_q;
    assign a_o   = a_q;
    assign b_o   = b_q;
    assign s_o   = s_q;
endmodule

module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = WIDTH / STAGES;

    logic [STAGES:0][WIDTH-1:0] a_p, b_p, s_p;
    logic [STAGES:0]            v_p, c_p;
    logic [STAGES-1:0]          ovf_p;
    logic                       stall;

    // a stalled output freezes the whole pipe; bubbles are never squeezed out
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    assign v_p[0] = in_valid;
    assign c_p[0] = cin ^ sub;
    assign a_p[0] = a;
    assign b_p[0] = b ^ {WIDTH{sub}};
    assign s_p[0] = '0;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stg
            pipelined_addsub_stage #(
                .WIDTH(WIDTH),
                .CW   (CW),
                .IDX  (k),
                .LAST (k == STAGES-1)
            ) u_stg (
                .clk  (clk),
                .rst  (rst),
                .en_i (~stall),
                .v_i  (v_p[k]),
                .c_i  (c_p[k]),
                .a_i  (a_p[k]),
                .b_i  (b_p[k]),
                .s_i  (s_p[k]),
                .v_o  (v_p[k+1]),
                .c_o  (c_p[k+1]),
                .ovf_o(ovf_p[k]),
                .a_o  (a_p[k+1]),
                .b_o  (b_p[k+1]),
                .s_o  (s_p[k+1])
            );
        end
    endgenerate

    assign out_valid = v_p[STAGES];
    assign sum       = s_p[STAGES];
    assign cout      = c_p[STAGES];
    assign ovf       = ovf_p[STAGES-1];
endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=16, STAGES=4): directed cases, backpressure, reset, random traffic.
module tb_pipelined_addsub;
    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W+1:0] exp_q[$];
    logic [W-1:0] log_q[$];
    logic         hold_prev = 1'b0;
    logic [W+1:0] prev_out;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // {ovf, cout, sum} straight from the arithmetic definition
    function automatic logic [W+1:0] model(input logic [W-1:0] x, y, input logic c, s);
        logic [W-1:0] ey;
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         ov;
        ey   = y ^ {W{s}};
        full = {1'b0, x} + {1'b0, ey} + {{W{1'b0}}, c ^ s};
        ov   = (x[W-1] == ey[W-1]) && (full[W-1] != x[W-1]);
        r    = full[W-1:0];
`ifdef SATURATE_EN
        if (ov) r = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return {ov, full[W], r};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (hold_prev) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_out", {14'd0, ovf, cout, sum}, {14'd0, prev_out});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", {16'd0, sum}, 32'hDEAD_BEEF);
                else begin
                    logic [W+1:0] e;
                    e = exp_q.pop_front();
                    chk("result", {14'd0, ovf, cout, sum}, {14'd0, e});
                    log_q.push_back(sum);
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_out  = {ovf, cout, sum};
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
        end
    end

    // call at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic send(input logic [W-1:0] x, y, input logic c, s);
        logic acc;
        int   g;
        g = 0;
        a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
        forever begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) break;
            g++;
            if (g > 200) begin chk("send_timeout", 32'd1, 32'd0); break; end
        end
        in_valid = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [W-1:0] x, y, input logic c, s,
                            input logic [W-1:0] es, input logic ec, eo);
        send(x, y, c, s);
        repeat (S-2) @(posedge clk);
        #1 chk({nm, "_early"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        @(posedge clk); #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] pick[5];
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {14'd0, ovf, cout, sum}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("model_pin_a", {14'd0, model(16'h00FF, 16'h0001, 0, 0)}, 32'h0_0100);
        chk("model_pin_b", {14'd0, model(16'h0005, 16'h0007, 0, 1)}, 32'h0_FFFE);
        chk("model_pin_c", {14'd0, model(16'hFFFF, 16'hFFFF, 1, 0)}, 32'h1_FFFF);

        directed("chunk_carry", 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
        directed("full_wrap",   16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        directed("sub_borrow",  16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
        directed("all_ones",    16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0);
`ifdef SATURATE_EN
        directed("pos_ovf",     16'h7FFF, 16'h0001, 0, 0, 16'h7FFF, 0, 1);
        directed("neg_ovf",     16'h8000, 16'h0001, 0, 1, 16'h8000, 1, 1);
`else
        directed("pos_ovf",     16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        directed("neg_ovf",     16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
`endif

        // backpressure: 8 beats back to back, 3-cycle stall once the first result shows
        log_q.delete();
        fork
            begin
                for (int i = 1; i <= 8; i++) send(W'(i), W'(16'h0100 * i), 1'b0, 1'b0);
            end
            begin
                int g;
                g = 0;
                forever begin
                    @(posedge clk); #2;
                    if (out_valid || g > 50) break;
                    g++;
                end
                chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
                out_ready = 1'b0;
                #1 chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        repeat (S + 4) @(posedge clk);
        #1;
        chk("bp_count", log_q.size(), 32'd8);
        for (int i = 1; i <= 8 && i <= log_q.size(); i++)
            chk("bp_order", {16'd0, log_q[i-1]}, 32'h0101 * i);

        // reset with beats in flight
        send(16'h1111, 16'h0001, 0, 0);
        send(16'h2222, 16'h0002, 0, 0);
        send(16'h3333, 16'h0003, 0, 0);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out", {14'd0, ovf, cout, sum}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        repeat (S + 2) @(posedge clk);
        #1;
        directed("after_rst", 16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0);

        // random traffic with random backpressure
        for (int c = 0; c < 600; c++) begin
            pick[0] = 16'h0000; pick[1] = 16'hFFFF; pick[2] = 16'h7FFF; pick[3] = 16'h8000;
            pick[4] = W'($urandom);
            a         = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : W'($urandom);
            b         = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : W'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (S + 4) @(posedge clk);
        #1 chk("drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
